// File: rtl/ritc_storage_readout_ctrl.sv
// ritc_storage_readout_ctrl
//   Event sequencer for the RITC sample-storage buffer, user clock domain only.
//   Arms on request, fires a capture on an external/software trigger, waits
//   for capture completion, then reads every channel of every address over
//   the storage user port. The words leave as a 32-bit valid/ready stream
//   (one header word followed by DEPTH*NCHAN samples, address-major,
//   channel-minor). The buffer is cleared after each event.
//
// Ports
//   user_clk_i, user_rst_n_i   clock, synchronous active-low reset
//   arm_i, ext_trig_i,
//   soft_trig_i, abort_i       control pulses
//   stor_trig_o, stor_clear_o  single-cycle capture start / buffer clear
//   stor_addr_o, stor_sel_o,
//   stor_rd_o, stor_wr_o       storage user port (pointer load / advance)
//   stor_dat_i                 read data, combinational on stor_addr_o[10:8]
//   stor_done_i                capture complete (level)
//   stor_sync_latch_i          sync phase, captured into the header
//   out_dat_o, out_valid_o,
//   out_last_o, out_ready_i    event word stream
//   busy_o, armed_o            status
//   timeout_o                  sticky done-wait timeout, cleared by arm_i
//   event_count_o              completed events (wraps)
module ritc_storage_readout_ctrl #(
  parameter int NCHAN        = 6,
  parameter int DEPTH        = 1024,
  parameter int RD_LATENCY   = 2,
  parameter int DONE_TIMEOUT = 4095
) (
  input  logic        user_clk_i,
  input  logic        user_rst_n_i,
  input  logic        arm_i,
  input  logic        ext_trig_i,
  input  logic        soft_trig_i,
  input  logic        abort_i,
  output logic        stor_trig_o,
  output logic        stor_clear_o,
  output logic [10:0] stor_addr_o,
  output logic        stor_sel_o,
  output logic        stor_rd_o,
  output logic        stor_wr_o,
  input  logic [31:0] stor_dat_i,
  input  logic        stor_done_i,
  input  logic        stor_sync_latch_i,
  output logic [31:0] out_dat_o,
  output logic        out_valid_o,
  output logic        out_last_o,
  input  logic        out_ready_i,
  output logic        busy_o,
  output logic        armed_o,
  output logic        timeout_o,
  output logic [15:0] event_count_o
);

  localparam int W_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int L_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam int T_W = $clog2(DONE_TIMEOUT + 1);

  localparam logic [2:0]     CH_LAST = 3'(NCHAN - 1);
  localparam logic [W_W-1:0] W_LAST  = W_W'(DEPTH - 1);
  localparam logic [L_W-1:0] L_LAST  = L_W'(RD_LATENCY - 1);
  localparam logic [T_W-1:0] T_LAST  = T_W'(DONE_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_CLEAR, S_CLRWAIT, S_IDLE, S_ARMED, S_TRIG, S_WAITDONE,
    S_HEADER, S_SETPTR, S_LAT, S_CHAN, S_ADV
  } state_t;

  state_t         state;
  logic [2:0]     ch;
  logic [W_W-1:0] w;
  logic [L_W-1:0] lcnt;
  logic [T_W-1:0] tcnt;
  logic           hdr_sync;
  logic           in_hdr;
  logic           accept;

  assign accept = out_valid_o && out_ready_i;

  // Sample words are passed straight through from the storage read mux; the
  // address is held for the whole word, so the data stays stable in a stall.
  assign out_dat_o = !out_valid_o ? 32'd0 :
                     in_hdr       ? {4'hA, hdr_sync, 11'b0, event_count_o} :
                                    stor_dat_i;

  function automatic logic is_last(input logic [2:0] c, input logic [W_W-1:0] a);
    return (c == CH_LAST) && (a == W_LAST);
  endfunction

  always_ff @(posedge user_clk_i) begin
    if (!user_rst_n_i) begin
      state         <= S_CLEAR;
      stor_trig_o   <= 1'b0;
      stor_clear_o  <= 1'b0;
      stor_addr_o   <= '0;
      stor_sel_o    <= 1'b0;
      stor_rd_o     <= 1'b0;
      stor_wr_o     <= 1'b0;
      out_valid_o   <= 1'b0;
      out_last_o    <= 1'b0;
      busy_o        <= 1'b0;
      armed_o       <= 1'b0;
      timeout_o     <= 1'b0;
      event_count_o <= '0;
      ch            <= '0;
      w             <= '0;
      lcnt          <= '0;
      tcnt          <= '0;
      in_hdr        <= 1'b0;
    end else begin
      stor_trig_o  <= 1'b0;
      stor_clear_o <= 1'b0;
      stor_sel_o   <= 1'b0;
      stor_rd_o    <= 1'b0;
      stor_wr_o    <= 1'b0;
      if (arm_i) timeout_o <= 1'b0;

      if (abort_i && !(state inside {S_CLEAR, S_CLRWAIT, S_IDLE})) begin
        state        <= S_CLEAR;
        stor_clear_o <= 1'b1;
        stor_addr_o  <= '0;
        out_valid_o  <= 1'b0;
        out_last_o   <= 1'b0;
        in_hdr       <= 1'b0;
        armed_o      <= 1'b0;
        busy_o       <= 1'b1;
      end else begin
        case (state)
          // Normal entry raises the clear strobe on the way in; coming out of
          // reset it is still low, so issue it here first.
          S_CLEAR: begin
            busy_o <= 1'b1;
            if (stor_clear_o) begin
              state <= S_CLRWAIT;
              tcnt  <= '0;
            end else begin
              stor_clear_o <= 1'b1;
            end
          end
          S_CLRWAIT: begin
            if (!stor_done_i) begin
              state  <= S_IDLE;
              busy_o <= 1'b0;
            end else if (tcnt == T_LAST) begin
              timeout_o <= 1'b1;
              state     <= S_IDLE;
              busy_o    <= 1'b0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_IDLE: begin
            if (arm_i) begin
              state   <= S_ARMED;
              armed_o <= 1'b1;
            end
          end
          S_ARMED: begin
            if (ext_trig_i || soft_trig_i) begin
              state       <= S_TRIG;
              stor_trig_o <= 1'b1;
              armed_o     <= 1'b0;
              busy_o      <= 1'b1;
            end
          end
          S_TRIG: begin
            state <= S_WAITDONE;
            tcnt  <= '0;
          end
          S_WAITDONE: begin
            if (stor_done_i) begin
              state       <= S_HEADER;
              out_valid_o <= 1'b1;
              in_hdr      <= 1'b1;
              hdr_sync    <= stor_sync_latch_i;
            end else if (tcnt == T_LAST) begin
              timeout_o    <= 1'b1;
              state        <= S_CLEAR;
              stor_clear_o <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
          S_HEADER: begin
            if (accept) begin
              state       <= S_SETPTR;
              out_valid_o <= 1'b0;
              in_hdr      <= 1'b0;
              stor_sel_o  <= 1'b1;
              stor_wr_o   <= 1'b1;
              stor_addr_o <= '0;
              w           <= '0;
            end
          end
          S_SETPTR: begin
            state <= S_LAT;
            lcnt  <= '0;
          end
          S_LAT: begin
            if (lcnt == L_LAST) begin
              state       <= S_CHAN;
              ch          <= '0;
              stor_addr_o <= '0;
              out_valid_o <= 1'b1;
              out_last_o  <= is_last(3'd0, w);
            end else begin
              lcnt <= lcnt + 1'b1;
            end
          end
          S_CHAN: begin
            if (accept) begin
              if (ch != CH_LAST) begin
                ch          <= ch + 3'd1;
                stor_addr_o <= {ch + 3'd1, 8'b0};
                out_last_o  <= is_last(ch + 3'd1, w);
              end else if (w != W_LAST) begin
                state       <= S_ADV;
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
                stor_sel_o  <= 1'b1;
                stor_rd_o   <= 1'b1;
                stor_addr_o <= '0;
              end else begin
                event_count_o <= event_count_o + 16'd1;
                state         <= S_CLEAR;
                stor_clear_o  <= 1'b1;
                out_valid_o   <= 1'b0;
                out_last_o    <= 1'b0;
                stor_addr_o   <= '0;
              end
            end
          end
          S_ADV: begin
            w     <= w + 1'b1;
            state <= S_LAT;
            lcnt  <= '0;
          end
          default: state <= S_CLEAR;
        endcase
      end
    end
  end

endmodule
